// File: rtl/ram_sync_param.sv
// rtl/ram_sync_param.sv - single-port synchronous RAM with registered read and full-array clear sweep
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset (array contents are preserved)
//   req       access request, accepted when ready is high
//   we        1 = write, 0 = read (qualified by req)
//   addr      word address
//   wdata     write data
//   ready     block can accept req this cycle
//   rdata     registered read data, holds its value between reads
//   rvalid    rdata carries the read accepted on the previous edge
//   clr       start a clear sweep that writes CLR_VALUE to every word
//   busy      clear sweep in progress
//   clr_done  one-cycle pulse after the last word has been cleared

module ram_sync_param #(
    parameter int                 DATA_W    = 8,
    parameter int                 ADDR_W    = 4,
    parameter logic [DATA_W-1:0]  CLR_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic              clr,
    output logic              busy,
    output logic              clr_done
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    // One bit wider than the address so the sweep can never wrap back onto word 0.
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_nxt;

    logic              acc;
    logic              rd_acc;
    logic              sweep_last;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    // clr takes priority over a request presented in the same cycle.
    assign ready      = (state == IDLE) && !clr;
    assign busy       = (state == CLEAR);
    assign acc        = req && ready;
    assign rd_acc     = acc && !we;
    assign sweep_last = busy && (cnt == LAST_CNT);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == IDLE) begin
            if (clr) begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        end else begin
            cnt_nxt = cnt + CNT_ONE;
            if (sweep_last) begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Single write port shared by the sweep and user writes. Gating with rst_n
    // makes a reset mid-sweep stop before touching the current word.
    always_comb begin
        mem_we    = rst_n && (busy || (acc && we));
        mem_waddr = busy ? cnt[ADDR_W-1:0] : addr;
        mem_wdata = busy ? CLR_VALUE : wdata;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata    <= '0;
            rvalid   <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            rvalid   <= rd_acc;
            clr_done <= sweep_last;
            if (rd_acc) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: tb/tb_ram_sync_param.sv
// tb/tb_ram_sync_param.sv - scoreboard bench for ram_sync_param against a behavioural array model

module tb_ram_sync_param;

    logic       clk = 1'b0;
    logic       rst_n, req, we, clr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       ready, rvalid, busy, clr_done;
    logic [7:0] rdata;

    logic        rst_n2, req2, we2, clr2;
    logic [5:0]  addr2;
    logic [15:0] wdata2;
    logic        ready2, rvalid2, busy2, clr_done2;
    logic [15:0] rdata2;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [16];
    logic [7:0] exp_q [$];
    int         rv_run = 0;
    int         rv_max_run = 0;

    always #5 clk = ~clk;

    ram_sync_param #(.DATA_W(8), .ADDR_W(4), .CLR_VALUE(8'h00)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata), .rvalid(rvalid), .clr(clr), .busy(busy), .clr_done(clr_done)
    );

    ram_sync_param #(.DATA_W(16), .ADDR_W(6), .CLR_VALUE(16'hBEEF)) u1 (
        .clk(clk), .rst_n(rst_n2), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
        .ready(ready2), .rdata(rdata2), .rvalid(rvalid2), .clr(clr2), .busy(busy2), .clr_done(clr_done2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rvalid cycle consumes one expected word from the scoreboard.
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            rv_run = rv_run + 1;
            if (rv_run > rv_max_run) rv_max_run = rv_run;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: got rdata 0x%0h expected no read", rdata);
            end else begin
                chk("rdata", {24'd0, rdata}, {24'd0, exp_q.pop_front()});
            end
        end else begin
            rv_run = 0;
        end
    end

    task automatic access(input logic w, input logic [3:0] a, input logic [7:0] d);
        req = 1'b1; we = w; addr = a; wdata = d;
        if (w) ref_mem[a] = d;
        else   exp_q.push_back(ref_mem[a]);
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (3) @(posedge clk);
        #1;
        chk(name, exp_q.size(), 0);
    endtask

    task automatic fill(input logic [7:0] v);
        for (int a = 0; a < 16; a++) access(1'b1, a[3:0], v);
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) access(1'b0, a[3:0], 8'h00);
    endtask

    // Issue clr (optionally with a competing write) for one cycle; the sweep
    // begins on the following edge.
    task automatic start_clear(input logic with_req, input logic [3:0] a, input logic [7:0] d);
        clr = 1'b1; req = with_req; we = 1'b1; addr = a; wdata = d;
        #1;
        chk("ready_low_with_clr", ready, 0);
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    // Observe a sweep at negedges; optionally re-pulse clr or apply reset at a given sweep cycle.
    task automatic sweep_watch(input int mid_clr_at, input int rst_at,
                               output int nbusy, output int ndone, output int nready);
        nbusy = 0; ndone = 0; nready = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (clr_done) ndone++;
            if (busy && ready) nready++;
            clr   = (i == mid_clr_at);
            rst_n = (i != rst_at);
        end
        clr = 1'b0; rst_n = 1'b1;
    endtask

    int nb, nd, nr;

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; clr = 1'b0; addr = '0; wdata = '0;
        rst_n2 = 1'b0; req2 = 1'b0; we2 = 1'b0; clr2 = 1'b0; addr2 = '0; wdata2 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; rst_n2 = 1'b1;
        chk("rst_rdata", rdata, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_clr_done", clr_done, 0);
        chk("rst_ready", ready, 1);

        // Write then read the same address on the next cycle.
        access(1'b1, 4'd3, 8'hA5);
        access(1'b0, 4'd3, 8'h00);
        drain("wr_rd_drain");

        // Back-to-back writes then 16 consecutive reads.
        for (int k = 0; k < 16; k++) access(1'b1, k[3:0], 8'(k + 16));
        rv_max_run = 0;
        read_all();
        drain("b2b_drain");
        chk("b2b_rvalid_run", rv_max_run, 16);

        // Clear sweep after filling with 0xFF.
        fill(8'hFF);
        start_clear(1'b0, 4'd0, 8'h00);
        sweep_watch(-1, -1, nb, nd, nr);
        for (int a = 0; a < 16; a++) ref_mem[a] = 8'h00;
        chk("clr_busy_cycles", nb, 16);
        chk("clr_done_pulses", nd, 1);
        chk("clr_ready_during", nr, 0);
        read_all();
        drain("clr_drain");

        // clr wins over a same-cycle write; re-pulsing clr mid-sweep does not extend it.
        fill(8'h3C);
        start_clear(1'b1, 4'd5, 8'h77);
        sweep_watch(5, -1, nb, nd, nr);
        for (int a = 0; a < 16; a++) ref_mem[a] = 8'h00;
        chk("prio_busy_cycles", nb, 16);
        chk("prio_done_pulses", nd, 1);
        read_all();
        drain("prio_drain");

        // Reset on sweep cycle 6 aborts the clear.
        fill(8'hFF);
        start_clear(1'b0, 4'd0, 8'h00);
        sweep_watch(-1, 6, nb, nd, nr);
        for (int a = 0; a < 6; a++) ref_mem[a] = 8'h00;
        chk("rst_abort_done", nd, 0);
        chk("rst_abort_busy", busy, 0);
        chk("rst_abort_rvalid", rvalid, 0);
        chk("rst_abort_rdata", rdata, 0);
        read_all();
        drain("rst_abort_drain");

        // Random mix of reads, writes and idle cycles.
        for (int n = 0; n < 120; n++) begin
            int r;
            r = $urandom_range(0, 3);
            if (r == 0) begin
                @(posedge clk); #1;
            end else begin
                access(r == 1, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            end
        end
        drain("rand_drain");

        // Wide configuration: 64-word sweep writing 0xBEEF.
        @(negedge clk);
        req2 = 1'b1; we2 = 1'b1; addr2 = 6'd63; wdata2 = 16'h1234;
        @(negedge clk);
        req2 = 1'b0; clr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0;
        nb = 0; nd = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy2) nb++;
            if (clr_done2) nd++;
            @(negedge clk);
        end
        chk("p2_busy_cycles", nb, 64);
        chk("p2_done_pulses", nd, 1);
        for (int a = 0; a < 64; a += 63) begin
            req2 = 1'b1; we2 = 1'b0; addr2 = 6'(a);
            @(negedge clk);
            req2 = 1'b0;
            chk("p2_rvalid", rvalid2, 1);
            chk("p2_rdata", rdata2, 16'hBEEF);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
